// File: rtl/first_stage_sequencer.sv
// -----------------------------------------------------------------------------
// first_stage_sequencer
// Sequences element fetches and datapath strobes for a multi-layer vector run.
// For each layer it fetches VECTOR_LENGTH elements, one capture strobe per
// element. It then waits for the datapath's z result and emits one
// vector-finishing strobe. The run ends in DONE with a sticky finished flag.
//
// Ports
//   clock            rising-edge clock
//   clear_n          asynchronous active-low reset
//   go               start request (accepted in IDLE/DONE only)
//   abort            synchronous cancel of a run in progress
//   mem_valid        element data available for mem_addr
//   z_vector_ready   datapath finished the current vector
//   mem_req          element fetch request
//   mem_addr         {active_layer, element_index}
//   a_element_ready  capture strobe for a elements
//   b_element_ready  capture strobe for b elements (identical to a)
//   vector_finishing vector complete strobe
//   active_layer     current layer index
//   busy             run in progress
//   finished         run complete (sticky)
//   cycle_count      busy-cycle count of current/last run (saturating)
// -----------------------------------------------------------------------------
module first_stage_sequencer #(
    parameter int unsigned VECTOR_LENGTH = 16,
    parameter int unsigned NUM_LAYERS    = 4
) (
    input  logic                                 clock,
    input  logic                                 clear_n,
    input  logic                                 go,
    input  logic                                 abort,
    input  logic                                 mem_valid,
    input  logic                                 z_vector_ready,
    output logic                                 mem_req,
    output logic [2+$clog2(VECTOR_LENGTH)-1:0]   mem_addr,
    output logic                                 a_element_ready,
    output logic                                 b_element_ready,
    output logic                                 vector_finishing,
    output logic [1:0]                           active_layer,
    output logic                                 busy,
    output logic                                 finished,
    output logic [31:0]                          cycle_count
);

    localparam int unsigned EW = $clog2(VECTOR_LENGTH);
    localparam int unsigned CW = 32;

    localparam logic [EW-1:0] LAST_ELEM  = EW'(VECTOR_LENGTH - 1);
    localparam logic [1:0]    LAST_LAYER = 2'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_Z,
        S_FINISH_VEC,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   elem_q, elem_d;
    logic [1:0]      layer_q, layer_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_now;

    logic            mem_req_q;
    logic            strobe_q;
    logic            vfin_q;
    logic            busy_q;
    logic            finished_q;

    // Next-state, counters and busy-cycle counter
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        layer_d  = layer_q;
        count_d  = count_q;
        busy_now = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                   (state_q == S_WAIT_Z) || (state_q == S_FINISH_VEC);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d = S_FETCH;
                    elem_d  = '0;
                    layer_d = '0;
                    count_d = '0;
                end
            end
            S_FETCH: begin
                if (mem_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (elem_q == LAST_ELEM) begin
                    elem_d  = '0;
                    state_d = S_WAIT_Z;
                end else begin
                    elem_d  = elem_q + EW'(1);
                    state_d = S_FETCH;
                end
            end
            S_WAIT_Z: begin
                if (z_vector_ready) begin
                    state_d = S_FINISH_VEC;
                end
            end
            S_FINISH_VEC: begin
                if (layer_q == LAST_LAYER) begin
                    state_d = S_DONE;
                end else begin
                    layer_d = layer_q + 2'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every busy transition; the counter freezes on that edge.
        if (busy_now) begin
            if (abort) begin
                state_d = S_IDLE;
                elem_d  = '0;
                layer_d = '0;
                count_d = count_q;
            end else if (count_q != {CW{1'b1}}) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            layer_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            layer_q <= layer_d;
            count_q <= count_d;
        end
    end

    // Output flags registered from the next-state decode so they align with state_q
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            mem_req_q  <= 1'b0;
            strobe_q   <= 1'b0;
            vfin_q     <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            mem_req_q  <= (state_d == S_FETCH);
            strobe_q   <= (state_d == S_ISSUE);
            vfin_q     <= (state_d == S_FINISH_VEC);
            busy_q     <= (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                          (state_d == S_WAIT_Z) || (state_d == S_FINISH_VEC);
            finished_q <= (state_d == S_DONE);
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_addr         = {layer_q, elem_q};
    assign a_element_ready  = strobe_q;
    assign b_element_ready  = strobe_q;
    assign vector_finishing = vfin_q;
    assign active_layer     = layer_q;
    assign busy             = busy_q;
    assign finished         = finished_q;
    assign cycle_count      = count_q;

endmodule

// File: tb/tb_first_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_first_stage_sequencer
// Drives first_stage_sequencer (VECTOR_LENGTH=4, NUM_LAYERS=2) with directed
// and random stimulus, and compares every cycle against a plan-driven
// reference model. A second instance (VECTOR_LENGTH=2, NUM_LAYERS=1) covers
// the minimal configuration.
// -----------------------------------------------------------------------------
module tb_first_stage_sequencer;

    localparam int VL = 4;
    localparam int NL = 2;

    typedef enum int {K_FETCH, K_ISSUE, K_WAITZ, K_FIN} kind_e;
    typedef struct {
        kind_e kind;
        int    addr;
        int    layer;
    } step_t;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        go, abort, mem_valid, z_vector_ready;
    logic        mem_req, a_element_ready, b_element_ready, vector_finishing;
    logic [3:0]  mem_addr;
    logic [1:0]  active_layer;
    logic        busy, finished;
    logic [31:0] cycle_count;

    logic        go2;
    logic        mem_req2, a2, b2, vfin2, busy2, finished2;
    logic [2:0]  mem_addr2;
    logic [1:0]  active_layer2;
    logic [31:0] cycle_count2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    first_stage_sequencer #(.VECTOR_LENGTH(VL), .NUM_LAYERS(NL)) u_dut (
        .clock            (clock),
        .clear_n          (clear_n),
        .go               (go),
        .abort            (abort),
        .mem_valid        (mem_valid),
        .z_vector_ready   (z_vector_ready),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .a_element_ready  (a_element_ready),
        .b_element_ready  (b_element_ready),
        .vector_finishing (vector_finishing),
        .active_layer     (active_layer),
        .busy             (busy),
        .finished         (finished),
        .cycle_count      (cycle_count)
    );

    first_stage_sequencer #(.VECTOR_LENGTH(2), .NUM_LAYERS(1)) u_dut_min (
        .clock            (clock),
        .clear_n          (clear_n),
        .go               (go2),
        .abort            (1'b0),
        .mem_valid        (1'b1),
        .z_vector_ready   (1'b1),
        .mem_req          (mem_req2),
        .mem_addr         (mem_addr2),
        .a_element_ready  (a2),
        .b_element_ready  (b2),
        .vector_finishing (vfin2),
        .active_layer     (active_layer2),
        .busy             (busy2),
        .finished         (finished2),
        .cycle_count      (cycle_count2)
    );

    // Reference model: ordered list of run steps plus a cursor into it
    step_t  plan[$];
    bit     m_run;
    bit     m_fin;
    int     m_idx;
    longint m_cyc;
    int     m_idle_addr;
    int     m_idle_layer;

    // Observers of strobes
    int strobe_addrs[$];
    int n_vfin  = 0;
    int n_vfin2 = 0;
    int n_strobe2 = 0;
    int bad_layer2 = 0;

    always @(negedge clock) begin
        if (clear_n) begin
            if (a_element_ready) strobe_addrs.push_back(int'(mem_addr));
            if (vector_finishing) n_vfin++;
            if (vfin2) n_vfin2++;
            if (a2 && b2) n_strobe2++;
            if (active_layer2 != 2'd0) bad_layer2++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build_plan();
        plan.delete();
        for (int l = 0; l < NL; l++) begin
            for (int e = 0; e < VL; e++) begin
                plan.push_back('{K_FETCH, l * VL + e, l});
                plan.push_back('{K_ISSUE, l * VL + e, l});
            end
            plan.push_back('{K_WAITZ, l * VL, l});
            plan.push_back('{K_FIN,   l * VL, l});
        end
    endfunction

    function automatic void model_reset();
        m_run        = 1'b0;
        m_fin        = 1'b0;
        m_idx        = 0;
        m_cyc        = 0;
        m_idle_addr  = 0;
        m_idle_layer = 0;
    endfunction

    function automatic void model_step(input bit g, input bit ab, input bit mv, input bit zr);
        bit adv;
        if (!m_run) begin
            if (g) begin
                m_run = 1'b1;
                m_fin = 1'b0;
                m_idx = 0;
                m_cyc = 0;
            end
        end else if (ab) begin
            m_run        = 1'b0;
            m_fin        = 1'b0;
            m_idle_addr  = 0;
            m_idle_layer = 0;
        end else begin
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            case (plan[m_idx].kind)
                K_FETCH: adv = mv;
                K_WAITZ: adv = zr;
                default: adv = 1'b1;
            endcase
            if (adv) m_idx++;
            if (m_idx == plan.size()) begin
                m_run        = 1'b0;
                m_fin        = 1'b1;
                m_idle_addr  = (NL - 1) * VL;
                m_idle_layer = NL - 1;
            end
        end
    endfunction

    // Called at a falling edge: compare, drive, advance model, move to next falling edge
    task automatic run_cycle(input bit g, input bit ab, input bit mv, input bit zr);
        logic [5:0] exp_flags;
        int         exp_addr, exp_layer;
        kind_e      k;
        if (m_run) begin
            k         = plan[m_idx].kind;
            exp_addr  = plan[m_idx].addr;
            exp_layer = plan[m_idx].layer;
            exp_flags = {1'b1, 1'b0, k == K_FETCH, k == K_ISSUE, k == K_ISSUE, k == K_FIN};
        end else begin
            exp_addr  = m_idle_addr;
            exp_layer = m_idle_layer;
            exp_flags = {1'b0, m_fin, 4'b0000};
        end
        check_eq("flags", 32'({busy, finished, mem_req, a_element_ready, b_element_ready, vector_finishing}),
                 32'(exp_flags));
        check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check_eq("active_layer", 32'(active_layer), 32'(exp_layer));
        check_eq("cycle_count", cycle_count, m_cyc[31:0]);
        go             = g;
        abort          = ab;
        mem_valid      = mv;
        z_vector_ready = zr;
        model_step(g, ab, mv, zr);
        @(posedge clock);
        @(negedge clock);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock edge
    task automatic do_reset();
        clear_n        = 1'b0;
        go             = 1'b0;
        abort          = 1'b0;
        mem_valid      = 1'b1;
        z_vector_ready = 1'b1;
        #1;
        check_eq("rst_flags", 32'({busy, finished, mem_req, a_element_ready, b_element_ready, vector_finishing}), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_layer", 32'(active_layer), 32'd0);
        check_eq("rst_cycles", cycle_count, 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int guard;
        clear_n        = 1'b0;
        go             = 1'b0;
        abort          = 1'b0;
        mem_valid      = 1'b0;
        z_vector_ready = 1'b0;
        go2            = 1'b0;
        build_plan();
        model_reset();
        @(negedge clock);
        do_reset();

        // Inputs tied high: full run of 20 busy cycles, plus the minimal instance
        strobe_addrs.delete();
        n_vfin = 0;
        go2 = 1'b1;
        run_cycle(1, 0, 1, 1);
        go2 = 1'b0;
        for (int i = 0; i < 100 && !finished; i++) run_cycle(0, 0, 1, 1);
        #1;
        check_eq("t1_finished", 32'(finished), 32'd1);
        check_eq("t1_cycles", cycle_count, 32'd20);
        check_eq("t1_strobes", 32'(strobe_addrs.size()), 32'd8);
        check_eq("t1_vfin", 32'(n_vfin), 32'd2);
        foreach (strobe_addrs[i]) check_eq("t1_addr_seq", 32'(strobe_addrs[i]), 32'(i));
        check_eq("min_cycles", cycle_count2, 32'd6);
        check_eq("min_finished", 32'(finished2), 32'd1);
        check_eq("min_vfin", 32'(n_vfin2), 32'd1);
        check_eq("min_strobes", 32'(n_strobe2), 32'd2);
        check_eq("min_layer_nonzero", 32'(bad_layer2), 32'd0);

        // mem_valid arrives in the fourth cycle of every fetch
        strobe_addrs.delete();
        n_vfin = 0;
        run_cycle(1, 0, 0, 1);
        w = 0;
        for (int i = 0; i < 200 && !finished; i++) begin
            w = mem_req ? w + 1 : 0;
            run_cycle(0, 0, w >= 4, 1);
        end
        #1;
        check_eq("t2_finished", 32'(finished), 32'd1);
        check_eq("t2_cycles", cycle_count, 32'd44);
        check_eq("t2_strobes", 32'(strobe_addrs.size()), 32'd8);
        check_eq("t2_vfin", 32'(n_vfin), 32'd2);
        foreach (strobe_addrs[i]) check_eq("t2_addr_seq", 32'(strobe_addrs[i]), 32'(i));

        // Abort during the second fetch of layer 1 (address 5)
        run_cycle(1, 0, 0, 1);
        guard = 0;
        while (!(mem_req && mem_addr == 4'd5) && guard < 100) begin
            run_cycle(0, 0, !mem_req || mem_addr != 4'd5, 1);
            guard++;
        end
        check_eq("t3_reach_fetch5", 32'(guard < 100), 32'd1);
        run_cycle(0, 1, 1, 1);
        #1;
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_finished", 32'(finished), 32'd0);
        strobe_addrs.delete();
        n_vfin = 0;
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 1, 1);
        #1;
        check_eq("t3_no_strobes", 32'(strobe_addrs.size() + n_vfin), 32'd0);
        run_cycle(1, 0, 0, 0);
        #1;
        check_eq("t3_restart_req", 32'(mem_req), 32'd1);
        check_eq("t3_restart_addr", 32'(mem_addr), 32'd0);

        // Asynchronous reset while waiting for z
        guard = 0;
        while (!(busy && !mem_req && !a_element_ready && !vector_finishing) && guard < 100) begin
            run_cycle(0, 0, 1, 0);
            guard++;
        end
        check_eq("t4_reach_waitz", 32'(guard < 100), 32'd1);
        n_vfin = 0;
        do_reset();
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 1, 1);
        #1;
        check_eq("t4_no_vfin", 32'(n_vfin), 32'd0);

        // go held high through a whole run with stray mem_valid / z pulses
        n_vfin = 0;
        guard = 0;
        run_cycle(1, 0, 1, 1);
        while (!finished && guard < 500) begin
            run_cycle(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        check_eq("t5_reach_done", 32'(finished), 32'd1);
        check_eq("t5_vfin", 32'(n_vfin), 32'd2);
        run_cycle(1, 0, 0, 0);
        #1;
        check_eq("t5_restart_fin", 32'(finished), 32'd0);
        check_eq("t5_restart_busy", 32'(busy), 32'd1);

        // Randomized traffic, occasional abort/reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                run_cycle($urandom_range(0, 7) == 0,
                          $urandom_range(0, 39) == 0,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/first_stage_sequencer.md
FIRST_STAGE_SEQUENCER -- requirements
Module: first_stage_sequencer

Interface
REQ-001 Parameter VECTOR_LENGTH, default 16, meaning elements per input vector; legal range 2..256.
REQ-002 Parameter NUM_LAYERS, default 4, meaning layers per run; legal range 1..4.
REQ-003 Local width EW = clog2(VECTOR_LENGTH); address width AW = 2+EW.
REQ-004 clock  input  1  rising-edge clock; only clock domain.
REQ-005 clear_n  input  1  asynchronous active-low reset.
REQ-006 go  input  1  start request, sampled in IDLE and DONE only.
REQ-007 abort  input  1  synchronous cancel of a run in progress.
REQ-008 mem_valid  input  1  element memory has a0..a3/b0..b3 data for mem_addr this cycle.
REQ-009 z_vector_ready  input  1  datapath has finished the current vector's z result.
REQ-010 mem_req  output  1  element fetch request.
REQ-011 mem_addr  output  AW  {active_layer, element_index}.
REQ-012 a_element_ready  output  1  one-cycle strobe: datapath captures the a elements.
REQ-013 b_element_ready  output  1  one-cycle strobe: datapath captures the b elements; always equals a_element_ready.
REQ-014 vector_finishing  output  1  one-cycle strobe: vector complete, datapath advances layer and clears its accumulator.
REQ-015 active_layer  output  2  current layer index.
REQ-016 busy  output  1  run in progress.
REQ-017 finished  output  1  run complete, sticky.
REQ-018 cycle_count  output  32  busy-cycle count of the current/last run.

Function
REQ-019 States: IDLE, FETCH, ISSUE, WAIT_Z, FINISH_VEC, DONE; encoding free.
REQ-020 IDLE/DONE + go=1 -> FETCH; element_index=0, active_layer=0, cycle_count=0, finished=0.
REQ-021 FETCH: mem_req=1, mem_addr held stable; mem_valid=1 -> ISSUE, else stay; no timeout.
REQ-022 ISSUE (exactly one cycle): a_element_ready=b_element_ready=1; element_index==VECTOR_LENGTH-1 -> WAIT_Z with element_index<=0; else element_index+1 and -> FETCH.
REQ-023 WAIT_Z: z_vector_ready=1 -> FINISH_VEC, else stay.
REQ-024 FINISH_VEC (exactly one cycle): vector_finishing=1; active_layer==NUM_LAYERS-1 -> DONE; else active_layer+1 and -> FETCH.
REQ-025 DONE: finished=1, held until next accepted go or reset.
REQ-026 busy=1 exactly in FETCH, ISSUE, WAIT_Z, FINISH_VEC.
REQ-027 cycle_count increments by 1 on every clock edge where busy=1; holds otherwise; saturates at 0xFFFFFFFF.
REQ-028 mem_valid outside FETCH, and z_vector_ready outside WAIT_Z, are ignored with no side effect.
REQ-029 go while busy=1 is ignored.
REQ-030 abort=1 while busy=1 -> IDLE next edge: no strobe that cycle, finished stays 0, cycle_count holds, active_layer/element_index reset to 0.
REQ-031 abort takes priority over mem_valid, z_vector_ready and every state transition in the same cycle; abort in IDLE/DONE is ignored.
REQ-032 abort and go asserted together in DONE: go wins, new run starts.
REQ-033 All outputs are registered or pure state decodes; no combinational path from any input to any output.
REQ-034 Strobes never overlap: vector_finishing and a_element_ready are never both 1.

Reset
REQ-035 clear_n=0 asynchronously forces IDLE; all outputs 0, cycle_count 0, counters 0.
REQ-036 Reset mid-run discards the run with no strobe emitted; first edge with clear_n=1 evaluates IDLE.

Verification (VECTOR_LENGTH=4, NUM_LAYERS=2)
REQ-037 go pulse, mem_valid and z_vector_ready tied 1 -> 8 a/b strobes, 2 vector_finishing strobes, mem_addr sequence 0,1,2,3,4,5,6,7, finished=1, cycle_count=20.
REQ-038 mem_valid delayed 3 cycles per fetch, z_vector_ready tied 1 -> same strobes and addresses, cycle_count=44, mem_addr stable while mem_req=1.
REQ-039 abort during the 2nd FETCH of layer 1 -> next cycle IDLE, busy=0, finished=0, no further strobes; a following go starts again at mem_addr 0.
REQ-040 clear_n pulsed low in WAIT_Z -> all outputs 0 immediately without a clock edge; z_vector_ready afterwards produces no vector_finishing.
REQ-041 go held high for the whole run plus mem_valid/z_vector_ready pulsed outside FETCH/WAIT_Z -> no restart while busy, no extra strobes; in DONE the held go restarts, finished drops to 0 next cycle.
REQ-042 NUM_LAYERS=1, VECTOR_LENGTH=2, inputs tied 1 -> active_layer stays 0, one vector_finishing, cycle_count=6.
